// File: rtl/regfile_scoreboard.sv
// Integer register file with write-first read bypass and per-register
// pending-write counters that hold issue until every source has retired.
module regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int PEND_W = 2,
  localparam int AW    = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_rd_value,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic [AW-1:0]   issue_rs1,
  input  logic [AW-1:0]   issue_rs2,
  output logic            issue_ready,
  output logic [XLEN-1:0] rs1_value,
  output logic [XLEN-1:0] rs2_value,
  input  logic            flush,
  output logic            busy_any,
  output logic            err_underflow
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [NREG-1:0][XLEN-1:0]   regs;
  logic [NREG-1:0][PEND_W-1:0] pend, pend_next;
  logic [NREG-1:0]             inc_v, dec_v;
  logic                        wb_live, uf;
  logic                        hit1, hit2, blk1, blk2;

  assign wb_live = wb_valid && (wb_rd != '0);

  // Read ports: x0 is zero, a same-cycle writeback wins over the array.
  always_comb begin
    rs1_value = regs[issue_rs1];
    rs2_value = regs[issue_rs2];
    if (wb_live && wb_rd == issue_rs1) rs1_value = wb_rd_value;
    if (wb_live && wb_rd == issue_rs2) rs2_value = wb_rd_value;
    if (issue_rs1 == '0) rs1_value = '0;
    if (issue_rs2 == '0) rs2_value = '0;
  end

  // A source is blocked only if its count exceeds the write retiring now.
  assign hit1 = wb_live && (wb_rd == issue_rs1);
  assign hit2 = wb_live && (wb_rd == issue_rs2);
  assign blk1 = pend[issue_rs1] > PEND_W'(hit1);
  assign blk2 = pend[issue_rs2] > PEND_W'(hit2);

  assign issue_ready = !flush && !blk1 && !blk2 && (pend[issue_rd] != PEND_MAX);

  assign inc_v = (issue_valid && issue_ready && issue_rd != '0) ? (NREG'(1) << issue_rd) : '0;
  assign dec_v = wb_live ? (NREG'(1) << wb_rd) : '0;

  always_comb begin
    pend_next = pend;
    uf        = 1'b0;
    if (flush) begin
      pend_next = '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (inc_v[r] && !dec_v[r]) begin
          pend_next[r] = pend[r] + 1'b1;
        end else if (dec_v[r] && !inc_v[r]) begin
          if (pend[r] == '0) uf = 1'b1;
          else               pend_next[r] = pend[r] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs          <= '0;
      pend          <= '0;
      err_underflow <= 1'b0;
      busy_any      <= 1'b0;
    end else begin
      if (wb_live) regs[wb_rd] <= wb_rd_value;
      pend     <= pend_next;
      busy_any <= |pend_next;
      if (uf) err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed vector bench for regfile_scoreboard: table of per-cycle inputs
// with expected outputs sampled mid-cycle, plus a flush/underflow sequence.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst, wb_valid, issue_valid, flush;
  logic [4:0]  wb_rd, issue_rd, issue_rs1, issue_rs2;
  logic [31:0] wb_rd_value, rs1_value, rs2_value;
  logic        issue_ready, busy_any, err_underflow;

  int checks = 0;
  int failures = 0;

  regfile_scoreboard #(.XLEN(32), .NREG(32), .PEND_W(2)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_rd_value(wb_rd_value),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_ready(issue_ready), .rs1_value(rs1_value), .rs2_value(rs2_value),
    .flush(flush), .busy_any(busy_any), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst, wv;
    logic [4:0]  wrd;
    logic [31:0] wval;
    logic        iv;
    logic [4:0]  ird, rs1, rs2;
    logic        fl;
    logic        e_rdy;
    logic [31:0] e1, e2;
    logic        e_busy, e_err;
  } vec_t;

  function automatic vec_t mk(string name, logic r, logic wv, logic [4:0] wrd, logic [31:0] wval,
                              logic iv, logic [4:0] ird, logic [4:0] rs1, logic [4:0] rs2, logic fl,
                              logic e_rdy, logic [31:0] e1, logic [31:0] e2, logic e_busy, logic e_err);
    vec_t v;
    v.name = name; v.rst = r; v.wv = wv; v.wrd = wrd; v.wval = wval; v.iv = iv;
    v.ird = ird; v.rs1 = rs1; v.rs2 = rs2; v.fl = fl;
    v.e_rdy = e_rdy; v.e1 = e1; v.e2 = e2; v.e_busy = e_busy; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(string name, string field, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s got=%h expected=%h", name, field, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, check before the rising edge.
  task automatic step(vec_t v);
    @(negedge clk);
    rst = v.rst; wb_valid = v.wv; wb_rd = v.wrd; wb_rd_value = v.wval;
    issue_valid = v.iv; issue_rd = v.ird; issue_rs1 = v.rs1; issue_rs2 = v.rs2; flush = v.fl;
    #2;
    chk(v.name, "issue_ready", 32'(issue_ready), 32'(v.e_rdy));
    chk(v.name, "rs1_value", rs1_value, v.e1);
    chk(v.name, "rs2_value", rs2_value, v.e2);
    chk(v.name, "busy_any", 32'(busy_any), 32'(v.e_busy));
    chk(v.name, "err_underflow", 32'(err_underflow), 32'(v.e_err));
  endtask

  vec_t tbl[$];

  initial begin
    //               name      rst wv wrd  wval          iv ird rs1 rs2 fl  rdy e1            e2            busy err
    tbl.push_back(mk("rst_rd",  0, 0, 0,  32'h0,         0, 0,  5,  0,  0,  1, 32'h0,         32'h0,         0, 0));
    tbl.push_back(mk("iss7",    0, 0, 0,  32'h0,         1, 7,  0,  0,  0,  1, 32'h0,         32'h0,         0, 0));
    tbl.push_back(mk("byp7",    0, 1, 7,  32'hDEADBEEF,  0, 0,  7,  0,  0,  1, 32'hDEADBEEF,  32'h0,         1, 0));
    tbl.push_back(mk("rf7",     0, 0, 0,  32'h0,         0, 0,  7,  7,  0,  1, 32'hDEADBEEF,  32'hDEADBEEF,  0, 0));
    tbl.push_back(mk("wr_x0",   0, 1, 0,  32'h12345678,  0, 0,  0,  7,  0,  1, 32'h0,         32'hDEADBEEF,  0, 0));
    tbl.push_back(mk("iss3",    0, 0, 0,  32'h0,         1, 3,  0,  0,  0,  1, 32'h0,         32'h0,         0, 0));
    tbl.push_back(mk("raw3",    0, 0, 0,  32'h0,         1, 0,  3,  0,  0,  0, 32'h0,         32'h0,         1, 0));
    tbl.push_back(mk("wb3",     0, 1, 3,  32'hA5A5A5A5,  1, 0,  3,  3,  0,  1, 32'hA5A5A5A5,  32'hA5A5A5A5,  1, 0));
    tbl.push_back(mk("post3",   0, 0, 0,  32'h0,         0, 0,  3,  0,  0,  1, 32'hA5A5A5A5,  32'h0,         0, 0));
    tbl.push_back(mk("sat4a",   0, 0, 0,  32'h0,         1, 4,  0,  0,  0,  1, 32'h0,         32'h0,         0, 0));
    tbl.push_back(mk("sat4b",   0, 0, 0,  32'h0,         1, 4,  0,  0,  0,  1, 32'h0,         32'h0,         1, 0));
    tbl.push_back(mk("sat4c",   0, 0, 0,  32'h0,         1, 4,  0,  0,  0,  1, 32'h0,         32'h0,         1, 0));
    tbl.push_back(mk("sat4d",   0, 0, 0,  32'h0,         1, 4,  0,  0,  0,  0, 32'h0,         32'h0,         1, 0));
    tbl.push_back(mk("sat4wb",  0, 1, 4,  32'h44,        0, 4,  0,  0,  0,  0, 32'h0,         32'h0,         1, 0));
    tbl.push_back(mk("sat4e",   0, 0, 0,  32'h0,         1, 4,  0,  0,  0,  1, 32'h0,         32'h0,         1, 0));
    tbl.push_back(mk("drn4a",   0, 1, 4,  32'h1,         0, 0,  4,  0,  0,  0, 32'h1,         32'h0,         1, 0));
    tbl.push_back(mk("drn4b",   0, 1, 4,  32'h2,         0, 0,  4,  0,  0,  0, 32'h2,         32'h0,         1, 0));
    tbl.push_back(mk("drn4c",   0, 1, 4,  32'h3,         0, 0,  4,  0,  0,  1, 32'h3,         32'h0,         1, 0));
    tbl.push_back(mk("iss9",    0, 0, 0,  32'h0,         1, 9,  0,  0,  0,  1, 32'h0,         32'h0,         0, 0));
    tbl.push_back(mk("sim9",    0, 1, 9,  32'h99,        1, 9,  9,  0,  0,  1, 32'h99,        32'h0,         1, 0));
    tbl.push_back(mk("hold9",   0, 0, 0,  32'h0,         0, 0,  9,  0,  0,  0, 32'h99,        32'h0,         1, 0));
    tbl.push_back(mk("wb9",     0, 1, 9,  32'h9A,        0, 0,  0,  0,  0,  1, 32'h0,         32'h0,         1, 0));
    tbl.push_back(mk("idle9",   0, 0, 0,  32'h0,         0, 0,  9,  0,  0,  1, 32'h9A,        32'h0,         0, 0));

    // Reset asserted alongside write, issue and flush: reset must win.
    rst = 1'b1; wb_valid = 1'b1; wb_rd = 5'd5; wb_rd_value = 32'hFFFF_FFFF;
    issue_valid = 1'b1; issue_rd = 5'd5; issue_rs1 = 5'd0; issue_rs2 = 5'd0; flush = 1'b1;
    repeat (2) @(posedge clk);

    foreach (tbl[i]) step(tbl[i]);

    // Flush with in-flight writes, then a stale write raising sticky underflow.
    step(mk("fl_i2a",  0, 0, 0, 32'h0,  1, 2, 0, 0, 0,  1, 32'h0,  32'h0, 0, 0));
    step(mk("fl_i2b",  0, 0, 0, 32'h0,  1, 2, 0, 0, 0,  1, 32'h0,  32'h0, 1, 0));
    step(mk("fl_i6",   0, 0, 0, 32'h0,  1, 6, 0, 0, 0,  1, 32'h0,  32'h0, 1, 0));
    step(mk("flush",   0, 1, 6, 32'h55, 0, 0, 6, 2, 1,  0, 32'h55, 32'h0, 1, 0));
    step(mk("postfl",  0, 0, 0, 32'h0,  0, 2, 6, 2, 0,  1, 32'h55, 32'h0, 0, 0));
    step(mk("uf_wb2",  0, 1, 2, 32'h22, 0, 0, 2, 0, 0,  1, 32'h22, 32'h0, 0, 0));
    step(mk("uf_set",  0, 0, 0, 32'h0,  0, 0, 2, 0, 0,  1, 32'h22, 32'h0, 0, 1));
    step(mk("uf_hold", 0, 0, 0, 32'h0,  0, 0, 0, 0, 0,  1, 32'h0,  32'h0, 0, 1));
    step(mk("uf_rst",  1, 0, 0, 32'h0,  0, 0, 0, 0, 0,  1, 32'h0,  32'h0, 0, 1));
    step(mk("uf_clr",  0, 0, 0, 32'h0,  0, 0, 7, 6, 0,  1, 32'h0,  32'h0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Architectural integer register file with in-flight write tracking.
- Write end of the writeback path: consumes the per-cycle destination register and value produced by writeback.
- Read end: serves operand reads and hazard status to decode/issue.
- Keeps a per-register pending-write counter. Issue is stalled until every source operand's producing write has retired.

Parameters:
XLEN, 32, data width of each register
NREG, 32, number of architectural registers; register 0 is hardwired zero
PEND_W, 2, width of each pending counter; maximum outstanding writes per register = 2^PEND_W-1

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
wb_valid  input  1  writeback carries a register write this cycle
wb_rd  input  $clog2(NREG)  writeback destination register
wb_rd_value  input  XLEN  writeback data
issue_valid  input  1  decode presents an instruction
issue_rd  input  $clog2(NREG)  destination of presented instruction (0 = none)
issue_rs1  input  $clog2(NREG)  source 1 index
issue_rs2  input  $clog2(NREG)  source 2 index
issue_ready  output  1  instruction accepted this cycle when issue_valid && issue_ready
rs1_value  output  XLEN  source 1 operand
rs2_value  output  XLEN  source 2 operand
flush  input  1  pipeline flush; discards all scoreboard state
busy_any  output  1  some register has a nonzero pending count
err_underflow  output  1  sticky: a write retired to a register with pending count 0

Behaviour:
Reset (synchronous, rst=1 at posedge):
- All registers become 0. All pending counts become 0. err_underflow becomes 0.
- Outputs after reset: issue_ready=1 (with flush=0), busy_any=0, rs1_value/rs2_value=0.
- Reset overrides wb_valid, issue and flush in the same cycle.

Write port:
- At a posedge with wb_valid=1 and wb_rd!=0: reg[wb_rd] <= wb_rd_value.
- wb_rd=0 is ignored entirely: no write, no counter change, no error.

Read ports (combinational, write-first bypass):
- rsX_value = 0 if rsX=0.
- Otherwise rsX_value = wb_rd_value if wb_valid && wb_rd==rsX.
- Otherwise rsX_value = reg[rsX].
- A same-cycle write is therefore visible to the reader with zero latency.

Pending counters:
- Effective pending of rsX = pend[rsX] - (wb_valid && wb_rd==rsX && rsX!=0 ? 1 : 0), floored at 0.
- issue_ready = !flush && effective pending of rs1 == 0 && effective pending of rs2 == 0 && pend[issue_rd] != 2^PEND_W-1.
- Source index 0 never blocks. issue_rd=0 never blocks.
- issue_ready depends only on the current state and inputs, not on issue_valid.
- Accepted issue with issue_rd!=0: pend[issue_rd] increments at the posedge.
- Retiring write with wb_rd!=0: pend[wb_rd] decrements at the posedge.
- Increment and decrement of the same register in one cycle: count unchanged.
- Retiring write with pend[wb_rd]==0 and no same-cycle increment to that register: count stays 0 and err_underflow <= 1. err_underflow clears only on rst.
- Saturated counter (2^PEND_W-1) blocks any issue targeting that rd, so the counter never overflows.

Flush:
- flush=1 forces issue_ready=0.
- At the posedge, all pend counts become 0.
- A wb write in the same cycle still updates the register file and raises no underflow error.
- Writes that retire after a flush to registers with count 0 raise err_underflow. Upstream guarantees squashed instructions do not write back.

busy_any:
- Registered OR of all pending counts, taken from the post-update state.
- Equals 0 in the cycle after the last pending write retires.

Test Plan:
1. Reset then read: rst 1 cycle; rs1=5, rs2=0 -> rs1_value=0, rs2_value=0, issue_ready=1, busy_any=0.
2. Bypass: wb_valid=1, wb_rd=7, value 0xDEADBEEF, rs1=7 same cycle -> rs1_value=0xDEADBEEF immediately. Next cycle with wb_valid=0 -> still 0xDEADBEEF from the register file. A write to x0 leaves rs1=0 reading 0.
3. RAW stall:
   - Issue rd=3 -> pend[3]=1, busy_any=1.
   - Next cycle present rs1=3 -> issue_ready=0.
   - Cycle with wb_rd=3 -> issue_ready=1 in that same cycle, rs1_value=wb value.
   - Following cycle: pend[3]=0, busy_any=0.
4. Saturation: issue rd=4 three times with no writeback (PEND_W=2) -> fourth issue rd=4 gets issue_ready=0. One wb_rd=4 -> next cycle issue rd=4 accepted.
5. Simultaneous: pend[9]=1; same cycle accept issue rd=9 and wb_rd=9 -> pend[9] stays 1 and err_underflow stays 0.
6. Flush and underflow:
   - pend[2]=2, pend[6]=1; flush=1 with wb_rd=6 value 0x55 -> issue_ready=0 that cycle; next cycle all counts 0, reg6=0x55, err_underflow=0.
   - Later wb_rd=2 -> err_underflow=1 and stays 1 until rst.
